agc_mag_ctrl: RTL

Per-line automatic gain controller placed directly downstream of the sign/magnitude histogram block. It periodically scans every analysed ADC line through the histogram's `addr`/`lock` readout port and compares each line's magnitude-bit count against a target occupancy. It then steps a per-line gain code up or down with hysteresis, which is driven to the RF front-end attenuators.

---
 rtl/agc_pkg.sv | 36 +++
 rtl/agc_gain_step.sv | 31 +++
 rtl/agc_mag_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/agc_pkg.sv
// Shared types and helpers for the per-line AGC: FSM state enum, threshold
// math in 17-bit signed, and histogram window constants.
package agc_pkg;

    localparam int unsigned THR_W    = 17;
    localparam int unsigned WIN_SIZE = 65536;
    localparam int unsigned WIN_MID  = 32768;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_LOCK   = 3'd3,
        ST_WAIT_L = 3'd4,
        ST_SAMPLE = 3'd5,
        ST_ADJUST = 3'd6,
        ST_NEXT   = 3'd7
    } agc_state_e;

    // Lower dead-band edge, clamped at zero.
    function automatic logic signed [THR_W-1:0] agc_thr_lo(input int target, input int hyst);
        int t;
        t = target - hyst;
        if (t < 0) t = 0;
        return THR_W'(t);
    endfunction

    // Upper dead-band edge, clamped at the largest count a window can hold.
    function automatic logic signed [THR_W-1:0] agc_thr_hi(input int target, input int hyst);
        int t;
        t = target + hyst;
        if (t > int'(WIN_SIZE) - 1) t = int'(WIN_SIZE) - 1;
        return THR_W'(t);
    endfunction

endpackage

// File: rtl/agc_gain_step.sv
// Combinational gain stepper: +1 below the dead band, -1 above it,
// saturating at both ends of the gain code range.
module agc_gain_step
    import agc_pkg::*;
#(
    parameter int unsigned GAIN_W = 6
) (
    input  logic [GAIN_W-1:0]       i_gain,
    input  logic [15:0]             i_mag,
    input  logic signed [THR_W-1:0] i_lo,
    input  logic signed [THR_W-1:0] i_hi,
    output logic [GAIN_W-1:0]       o_gain_c
);

    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;

    logic signed [THR_W-1:0] w_mag_s;

    assign w_mag_s = $signed({1'b0, i_mag});

    // Compare magnitude count against the dead band and step with saturation.
    always_comb begin
        o_gain_c = i_gain;
        if (w_mag_s < i_lo) begin
            if (i_gain != GAIN_MAX) o_gain_c = i_gain + GAIN_W'(1);
        end else if (w_mag_s > i_hi) begin
            if (i_gain != '0) o_gain_c = i_gain - GAIN_W'(1);
        end
    end

endmodule

// File: rtl/agc_mag_ctrl.sv
// Per-line automatic gain controller. Periodically scans each histogram line
// through the addr/lock readout port and steps that line's gain code.
// Optional feature macro: AGC_DC_ALARM_EN (per-line sign-imbalance flag).
module agc_mag_ctrl
    import agc_pkg::*;
#(
    parameter int unsigned LINES         = 1,
    parameter int unsigned GAIN_W        = 6,
    parameter int unsigned GAIN_INIT     = 32,
    parameter int unsigned MAG_TARGET    = 21627,
    parameter int unsigned HYST          = 1024,
    parameter int unsigned SETTLE        = 4,
    parameter int unsigned UPDATE_PERIOD = 65536,
    parameter int unsigned SIG_TOL       = 4096
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      en,
    input  logic                      hist_valid,
    input  logic [31:0]               hist_result,
    output logic [7:0]                hist_addr,
    output logic                      hist_lock,
    output logic [LINES*GAIN_W-1:0]   gain,
    output logic                      gain_upd,
    output logic                      busy,
    output logic [LINES-1:0]          dc_alarm
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam int unsigned GV_W  = LINES * GAIN_W;

    localparam logic signed [THR_W-1:0] THR_LO    = agc_thr_lo(int'(MAG_TARGET), int'(HYST));
    localparam logic signed [THR_W-1:0] THR_HI    = agc_thr_hi(int'(MAG_TARGET), int'(HYST));
    localparam logic [7:0]              LAST_LINE = 8'(LINES - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0]        TMR_LAST  = TMR_W'(UPDATE_PERIOD - 1);
    localparam logic [GV_W-1:0]         GAIN_RST  = {LINES{GAIN_W'(GAIN_INIT)}};

    agc_state_e         r_state, w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic               r_pending;
    logic [7:0]         r_line, w_line_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]         r_addr, w_addr_nxt;
    logic               r_lock, w_lock_nxt;
    logic [15:0]        r_mag, w_mag_nxt;
    logic [GV_W-1:0]    r_gain, w_gain_nxt;
    logic               r_upd, w_upd_nxt;
    logic               r_busy;
    logic [GAIN_W-1:0]  w_cur_gain;
    logic [GAIN_W-1:0]  w_step_gain;
    logic               w_wrap;
    logic               w_start;

    assign w_wrap  = (r_timer == TMR_LAST);
    assign w_start = (r_state == ST_IDLE) && r_pending && en && hist_valid;

    // Free-running update period timer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_timer <= '0;
        else if (w_wrap) r_timer <= '0;
        else r_timer <= r_timer + TMR_W'(1);
    end

    // Scan request: a wrap always wins so a wrap mid-scan queues the next scan.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_pending <= 1'b0;
        else if (w_wrap) r_pending <= 1'b1;
        else if (w_start) r_pending <= 1'b0;
    end

    // Gain field of the line currently being processed.
    always_comb begin
        w_cur_gain = r_gain[GAIN_W-1:0];
        for (int i = 0; i < int'(LINES); i++) begin
            if (r_line == 8'(i)) w_cur_gain = r_gain[i*GAIN_W +: GAIN_W];
        end
    end

    agc_gain_step #(
        .GAIN_W (GAIN_W)
    ) u_gain_step (
        .i_gain   (w_cur_gain),
        .i_mag    (r_mag),
        .i_lo     (THR_LO),
        .i_hi     (THR_HI),
        .o_gain_c (w_step_gain)
    );

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_line  <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_lock  <= 1'b0;
            r_mag   <= '0;
            r_gain  <= GAIN_RST;
            r_upd   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_line  <= w_line_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_lock  <= w_lock_nxt;
            r_mag   <= w_mag_nxt;
            r_gain  <= w_gain_nxt;
            r_upd   <= w_upd_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state and next register values for the scan sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_line_nxt  = r_line;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_lock_nxt  = r_lock;
        w_mag_nxt   = r_mag;
        w_gain_nxt  = r_gain;
        w_upd_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_line_nxt  = '0;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_addr_nxt  = r_line;
                w_lock_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT_A;
            end
            ST_WAIT_A: begin
                if (r_cnt == CNT_LAST) w_state_nxt = ST_LOCK;
                else w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            ST_LOCK: begin
                w_lock_nxt  = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT_L;
            end
            ST_WAIT_L: begin
                if (r_cnt == CNT_LAST) w_state_nxt = ST_SAMPLE;
                else w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            ST_SAMPLE: begin
                w_mag_nxt   = hist_result[15:0];
                w_state_nxt = ST_ADJUST;
            end
            ST_ADJUST: begin
                for (int i = 0; i < int'(LINES); i++) begin
                    if (r_line == 8'(i)) w_gain_nxt[i*GAIN_W +: GAIN_W] = w_step_gain;
                end
                w_state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                if (r_line == LAST_LINE) begin
                    w_lock_nxt  = 1'b0;
                    w_upd_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_line_nxt  = r_line + 8'd1;
                    w_state_nxt = ST_ADDR;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef AGC_DC_ALARM_EN
    localparam logic signed [THR_W-1:0] SIG_MID_S = THR_W'(WIN_MID);
    localparam logic signed [THR_W-1:0] SIG_TOL_S = THR_W'(SIG_TOL);

    logic [15:0]             r_sig;
    logic [LINES-1:0]        r_dc, w_dc_nxt;
    logic signed [THR_W-1:0] w_sig_dev;
    logic signed [THR_W-1:0] w_sig_abs;
    logic                    w_dc_hit;

    assign w_sig_dev = $signed({1'b0, r_sig}) - SIG_MID_S;
    assign w_sig_abs = w_sig_dev[THR_W-1] ? -w_sig_dev : w_sig_dev;
    assign w_dc_hit  = (w_sig_abs > SIG_TOL_S);

    // Sign count captured alongside the magnitude count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_sig <= '0;
        else if (r_state == ST_SAMPLE) r_sig <= hist_result[31:16];
    end

    // Per-line imbalance flag, refreshed when that line is adjusted.
    always_comb begin
        w_dc_nxt = r_dc;
        if (r_state == ST_ADJUST) begin
            for (int i = 0; i < int'(LINES); i++) begin
                if (r_line == 8'(i)) w_dc_nxt[i] = w_dc_hit;
            end
        end
    end

    // DC alarm register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_dc <= '0;
        else r_dc <= w_dc_nxt;
    end

    assign dc_alarm = r_dc;
`else
    logic w_unused_sig;

    assign w_unused_sig = ^{hist_result[31:16], 32'(SIG_TOL), 32'(WIN_MID)};
    assign dc_alarm     = '0;
`endif

    assign hist_addr = r_addr;
    assign hist_lock = r_lock;
    assign gain      = r_gain;
    assign gain_upd  = r_upd;
    assign busy      = r_busy;

endmodule
